eth_f_pkt_tx_scheduler: RTL and testbench

//  Packet-boundary round-robin scheduler sharing one TX packet client interface between NUM_SRC packet sources.

---
 rtl/eth_f_pkt_sched_pkg.sv | 7 +
 rtl/eth_f_rr_pick.sv | 22 ++
 rtl/eth_f_pkt_tx_scheduler.sv | 106 ++++++++++
 tb/tb_eth_f_pkt_tx_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_f_pkt_sched_pkg.sv
// eth_f_pkt_sched_pkg: shared state encoding and ctrl-bit positions for the TX packet scheduler
package eth_f_pkt_sched_pkg;
    typedef enum logic {IDLE, XFER} state_t;
    localparam int SOP_POS     = 0;
    localparam int EOP_POS     = 1;
    localparam int INFRAME_POS = 8;
endpackage

// File: rtl/eth_f_rr_pick.sv
// eth_f_rr_pick: combinational round-robin picker, first set request at or after ptr
module eth_f_rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] ptr,
    output logic [$clog2(NUM_SRC)-1:0] gnt_idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_SRC);
    logic [IW-1:0] idx;
    // scanning from the far end lets the closest request to ptr win
    always_comb begin
        gnt_idx = '0;
        idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_SRC);
            gnt_idx = req[idx] ? idx : gnt_idx;
        end
    end
    assign any = |req;
endmodule

// File: rtl/eth_f_pkt_tx_scheduler.sv
// eth_f_pkt_tx_scheduler: packet-boundary round-robin scheduler sharing one TX client interface
module eth_f_pkt_tx_scheduler
    import eth_f_pkt_sched_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int CLIENT_IF_TYPE = 0,
    parameter int WORDS_MAC      = 8,
    parameter int DATA_BCNT      = 64,
    parameter int CTRL_BCNT      = 8,
    parameter int PTP_BCNT       = 24,
    parameter int CNT_W          = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tx_en,
    input  logic [NUM_SRC-1:0]             cfg_src_en,
    input  logic [3:0]                     cfg_burst,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*DATA_BCNT*8-1:0] src_data,
    input  logic [NUM_SRC*CTRL_BCNT*8-1:0] src_ctrl,
    input  logic [NUM_SRC*PTP_BCNT*8-1:0]  src_ptp,
    input  logic                           data_req,
    output logic                           din_vld,
    output logic [DATA_BCNT*8-1:0]         data_bus,
    output logic [CTRL_BCNT*8-1:0]         ctrl_bus,
    output logic [PTP_BCNT*8-1:0]          ptp_bus,
    output logic [$clog2(NUM_SRC)-1:0]     grant_id,
    output logic                           busy,
    input  logic                           stat_cnt_clr,
    output logic [NUM_SRC*CNT_W-1:0]       stat_pkt_cnt
);
    localparam int DW = DATA_BCNT * 8;
    localparam int CW = CTRL_BCNT * 8;
    localparam int PW = PTP_BCNT * 8;
    localparam int IW = $clog2(NUM_SRC);

    state_t              state;
    logic [IW-1:0]       g, ptr, pick;
    logic [3:0]          pkt_left;
    logic [NUM_SRC-1:0]  eligible;
    logic                any, xfer, eop, eop_xfer;
    logic [DW-1:0]       data_a [NUM_SRC];
    logic [CW-1:0]       ctrl_a [NUM_SRC];
    logic [PW-1:0]       ptp_a  [NUM_SRC];
    logic [CNT_W-1:0]    cnt    [NUM_SRC];

    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_src
            assign data_a[i] = src_data[i*DW +: DW];
            assign ctrl_a[i] = src_ctrl[i*CW +: CW];
            assign ptp_a[i]  = src_ptp[i*PW +: PW];
            assign stat_pkt_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    endgenerate

    assign eligible = src_valid & cfg_src_en;

    eth_f_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req     (eligible),
        .ptr     (ptr),
        .gnt_idx (pick),
        .any     (any)
    );

    assign busy      = (state == XFER);
    assign grant_id  = busy ? g : '0;
    assign din_vld   = busy & src_valid[g];
    assign src_ready = (busy & data_req) ? (NUM_SRC'(1) << g) : '0;
    assign data_bus  = busy ? data_a[g] : '0;
    assign ctrl_bus  = busy ? ctrl_a[g] : '0;
    assign ptp_bus   = busy ? ptp_a[g] : '0;
    assign xfer      = din_vld & data_req;
    // segmented layout marks the last beat by dropping the top inframe lane
    assign eop       = (CLIENT_IF_TYPE == 1) ? ctrl_bus[EOP_POS] : ~ctrl_bus[INFRAME_POS+WORDS_MAC-1];
    assign eop_xfer  = xfer & eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            g        <= '0;
            ptr      <= '0;
            pkt_left <= '0;
        end else if (state == IDLE) begin
            if (tx_en && any) begin
                g        <= pick;
                pkt_left <= (cfg_burst == 4'd0) ? 4'd1 : cfg_burst;
                state    <= XFER;
            end
        end else if (eop_xfer) begin
            pkt_left <= pkt_left - 4'd1;
            if (pkt_left == 4'd1 || !tx_en || !cfg_src_en[g]) begin
                ptr   <= (g == IW'(NUM_SRC - 1)) ? '0 : g + IW'(1);
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (rst || stat_cnt_clr) cnt[s] <= '0;
            else if (eop_xfer && g == IW'(s)) cnt[s] <= cnt[s] + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_eth_f_pkt_tx_scheduler.sv
// tb_eth_f_pkt_tx_scheduler: directed bench with AvST and segmented instances on shared stimulus
module tb_eth_f_pkt_tx_scheduler;
    localparam int NS = 4, DB = 64, CB = 8, PB = 24, CW = 4, SCW = 16;

    logic clk = 0, rst = 1, tx_en = 0, data_req = 0, stat_cnt_clr = 0;
    logic [NS-1:0] cfg_src_en = '0, src_valid = '0, en_src = '0;
    logic [3:0] cfg_burst = '0;
    logic [NS*DB*8-1:0] src_data = '0;
    logic [NS*CB*8-1:0] src_ctrl = '0;
    logic [NS*PB*8-1:0] src_ptp = '0;

    logic [NS-1:0] src_ready, s_src_ready;
    logic din_vld, busy, s_din_vld, s_busy;
    logic [DB*8-1:0] data_bus, s_data_bus;
    logic [CB*8-1:0] ctrl_bus, s_ctrl_bus;
    logic [PB*8-1:0] ptp_bus, s_ptp_bus;
    logic [1:0] grant_id, s_grant_id;
    logic [NS*CW-1:0] stat_pkt_cnt;
    logic [NS*SCW-1:0] s_stat_pkt_cnt;

    int len[NS], bi[NS], pn[NS], pkts[NS];
    int total = 0, stop_at = 0, beats = 0, cyc = 0;
    int order[$], starts[$];
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    eth_f_pkt_tx_scheduler #(.NUM_SRC(NS), .CLIENT_IF_TYPE(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .cfg_src_en(cfg_src_en), .cfg_burst(cfg_burst),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_ctrl(src_ctrl),
        .src_ptp(src_ptp), .data_req(data_req), .din_vld(din_vld), .data_bus(data_bus),
        .ctrl_bus(ctrl_bus), .ptp_bus(ptp_bus), .grant_id(grant_id), .busy(busy),
        .stat_cnt_clr(stat_cnt_clr), .stat_pkt_cnt(stat_pkt_cnt)
    );

    eth_f_pkt_tx_scheduler #(.NUM_SRC(NS), .CLIENT_IF_TYPE(0), .WORDS_MAC(8), .CNT_W(SCW)) dut_seg (
        .clk(clk), .rst(rst), .tx_en(tx_en), .cfg_src_en(cfg_src_en), .cfg_burst(cfg_burst),
        .src_valid(src_valid), .src_ready(s_src_ready), .src_data(src_data), .src_ctrl(src_ctrl),
        .src_ptp(src_ptp), .data_req(data_req), .din_vld(s_din_vld), .data_bus(s_data_bus),
        .ctrl_bus(s_ctrl_bus), .ptp_bus(s_ptp_bus), .grant_id(s_grant_id), .busy(s_busy),
        .stat_cnt_clr(stat_cnt_clr), .stat_pkt_cnt(s_stat_pkt_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] beat_id(int s);
        return {8'(s), 8'(pn[s]), 8'(bi[s])};
    endfunction

    function automatic logic [63:0] cnt(int s);
        return 64'(stat_pkt_cnt[s*CW +: CW]);
    endfunction

    function automatic logic [63:0] s_cnt(int s);
        return 64'(s_stat_pkt_cnt[s*SCW +: SCW]);
    endfunction

    // AvST eop sits in bit 1; the segmented top inframe lane drops to 0 on the same beat
    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            src_valid[s] = en_src[s];
            src_data[s*DB*8 +: DB*8] = {{(DB*8-24){1'b0}}, beat_id(s)};
            src_ptp[s*PB*8 +: PB*8] = {{(PB*8-24){1'b0}}, ~beat_id(s)};
            src_ctrl[s*CB*8 +: CB*8] = {48'b0, (bi[s] == len[s]-1) ? 8'h0F : 8'hFF, 6'b0,
                                        bi[s] == len[s]-1, bi[s] == 0};
        end
    endtask

    task automatic tick();
        logic [NS-1:0] hs;
        int s;
        @(negedge clk);
        hs = src_valid & src_ready;
        s = -1;
        for (int k = 0; k < NS; k++) if (hs[k]) s = k;
        if ((din_vld && data_req) || hs != '0)
            chk("xfer_match", 64'(din_vld & data_req), 64'(|hs));
        if (din_vld && data_req && s >= 0) begin
            chk("beat", 64'({ptp_bus[23:0], data_bus[23:0]}), 64'({~beat_id(s), beat_id(s)}));
            beats++;
            if (bi[s] == 0) begin order.push_back(s); starts.push_back(cyc); end
            if (bi[s] == len[s]-1) begin pkts[s]++; total++; end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NS; k++) begin
            if (hs[k]) begin
                if (bi[k] == len[k]-1) begin bi[k] = 0; pn[k]++; end
                else bi[k]++;
            end
        end
        if (total >= stop_at) en_src = '0;
        drive();
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        stop_at = target;
        for (int i = 0; i < budget && total < target; i++) tick();
        chk(tag, 64'(total >= target), 64'(1));
    endtask

    initial begin
        int exp2[9] = '{0, 0, 0, 2, 2, 2, 0, 0, 0};
        int t0, b0;
        for (int s = 0; s < NS; s++) begin len[s] = 3; bi[s] = 0; pn[s] = 0; pkts[s] = 0; end
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_grant", 64'(grant_id), 0);
        chk("rst_vld", 64'(din_vld), 0);
        chk("rst_ready", 64'(src_ready), 0);
        chk("rst_cnt", 64'(stat_pkt_cnt), 0);
        chk("rst_data", data_bus[63:0], 0);

        // round robin, burst 1, 3-beat packets from every source
        @(posedge clk); #1;
        rst = 0; tx_en = 1; cfg_src_en = '1; cfg_burst = 1; data_req = 1; en_src = '1;
        drive();
        run_until("p1_done", 8, 100);
        repeat (2) tick();
        chk("p1_npkt", 64'(order.size()), 8);
        for (int k = 0; k < order.size(); k++) chk("p1_order", 64'(order[k]), 64'(k % 4));
        for (int k = 1; k < starts.size(); k++) chk("p1_gap", 64'(starts[k] - starts[k-1]), 4);
        for (int s = 0; s < NS; s++) begin
            chk("p1_cnt", cnt(s), 2);
            chk("p1_seg_cnt", s_cnt(s), 2);
        end

        // burst of 3 between sources 0 and 2
        order.delete(); starts.delete();
        cfg_burst = 3; en_src = 4'b0101;
        drive();
        run_until("p2_done", total + 9, 200);
        repeat (2) tick();
        chk("p2_npkt", 64'(order.size()), 9);
        for (int k = 0; k < order.size() && k < 9; k++) chk("p2_order", 64'(order[k]), 64'(exp2[k]));
        if (starts.size() >= 4) begin
            chk("p2_b2b_gap", 64'(starts[1] - starts[0]), 3);
            chk("p2_switch_gap", 64'(starts[3] - starts[2]), 4);
        end
        chk("p2_cnt0", cnt(0), 8);
        chk("p2_cnt2", cnt(2), 5);
        chk("p2_idle", 64'(busy), 0);

        // source enable dropped mid-packet
        cfg_burst = 1; len[1] = 5; en_src = 4'b0010; stop_at = 1 << 30; b0 = beats; t0 = total;
        drive();
        for (int i = 0; i < 30 && bi[1] != 2; i++) tick();
        chk("p3_mid", 64'(bi[1]), 2);
        cfg_src_en = 4'b1101;
        for (int i = 0; i < 30 && total < t0 + 1; i++) tick();
        repeat (20) tick();
        chk("p3_beats", 64'(beats - b0), 5);
        chk("p3_pkts", 64'(pkts[1]), 3);
        chk("p3_cnt1", cnt(1), 3);
        chk("p3_no_regrant", 64'(busy), 0);

        // data_req toggling
        en_src = 4'b1000; cfg_src_en = '1; len[3] = 4; b0 = beats; stop_at = total + 2;
        drive();
        for (int i = 0; i < 100 && total < stop_at; i++) begin
            tick();
            data_req = ~data_req;
        end
        chk("p4_done", 64'(total >= stop_at), 1);
        data_req = 1;
        repeat (2) tick();
        chk("p4_beats", 64'(beats - b0), 8);
        chk("p4_cnt3", cnt(3), 4);

        // clear coinciding with an eop increment
        en_src = 4'b0001; len[0] = 3; stop_at = total + 1;
        drive();
        for (int i = 0; i < 30 && bi[0] != 2; i++) tick();
        chk("p5_pre", cnt(0), 8);
        stat_cnt_clr = 1;
        tick();
        stat_cnt_clr = 0;
        chk("p5_clr0", cnt(0), 0);
        chk("p5_clr_all", 64'(stat_pkt_cnt), 0);

        // burst 0 behaves as 1: bubble between single-beat packets
        starts.delete();
        cfg_burst = 0; len[0] = 1; en_src = 4'b0001;
        drive();
        run_until("b0_done", total + 2, 40);
        repeat (2) tick();
        chk("b0_nstart", 64'(starts.size()), 2);
        if (starts.size() >= 2) chk("b0_gap", 64'(starts[1] - starts[0]), 2);
        chk("b0_cnt", cnt(0), 2);

        // counter wrap, grant held while source is silent
        cfg_burst = 15; en_src = 4'b0001;
        drive();
        run_until("wrap_run", total + 13, 60);
        tick();
        chk("wrap_full", cnt(0), 15);
        chk("hold_busy", 64'(busy), 1);
        en_src = 4'b0001;
        drive();
        run_until("wrap_one", total + 1, 20);
        tick();
        chk("wrap_zero", cnt(0), 0);

        // reset, tx_en gating, segmented eop, reset mid-packet
        rst = 1;
        tick();
        rst = 0;
        chk("p6_rst_busy", 64'(busy), 0);
        chk("p6_seg_rst_cnt", 64'(s_stat_pkt_cnt), 0);
        tx_en = 0; cfg_burst = 1; en_src = 4'b0100; len[2] = 4; stop_at = 1 << 30;
        drive();
        repeat (5) tick();
        chk("txen_block", 64'(busy), 0);
        tx_en = 1; t0 = total;
        for (int i = 0; i < 40 && total < t0 + 1; i++) tick();
        chk("seg_cnt2", s_cnt(2), 1);
        chk("avst_cnt2", cnt(2), 1);
        for (int i = 0; i < 20 && bi[2] != 2; i++) tick();
        chk("p6_mid_busy", 64'(s_busy), 1);
        rst = 1;
        tick();
        chk("p6_rst_mid_seg", 64'(s_busy), 0);
        chk("p6_rst_mid", 64'(busy), 0);
        rst = 0; en_src = '0;
        drive();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
